// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: aligns an RGB565 pixel stream to frame boundaries and feeds the SDRAM write FIFO.
// Defining FRAME_WRITER_PATTERN_EN adds pattern_sel and a built-in 8-bar colour source.
module sdram_frame_writer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int CNT_W    = 19
) (
    input  logic        clk_lcd,
    input  logic        lcd_rst,
    input  logic        sdram_init_done,
    input  logic        wfifo_afull,
`ifdef FRAME_WRITER_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        wr_load,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  frame_cnt,
    output logic [2:0]  state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_LOAD  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TOTAL = CNT_W'(H_ACTIVE * V_ACTIVE);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      hold_q;
    logic [15:0]      data_q;
    logic             we_q;
    logic             wr_load_q;
    logic             done_q;
    logic             err_q;
    logic [7:0]       fcnt_q;

    logic             rdy_int;
    logic             src_valid;
    logic             src_sof;
    logic [15:0]      src_data;
    logic             accept;
    logic             last_px;

    // Handshake: a beat transfers on a rising clk_lcd edge where pix_valid && pix_ready;
    // pix_ready depends only on state, sdram_init_done and wfifo_afull, never on pix_valid.
    always_comb begin
        rdy_int = 1'b0;
        if (sdram_init_done) begin
            case (state_q)
                S_SYNC:  rdy_int = 1'b1;
                S_WRITE: rdy_int = ~wfifo_afull;
                default: rdy_int = 1'b0;
            endcase
        end
    end

    assign accept  = src_valid & rdy_int;
    assign last_px = ((cnt_q + CNT_W'(1)) == TOTAL);

`ifdef FRAME_WRITER_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic             pat_q;
    logic             pat_mode;
    logic [2:0]       bar_q;
    logic [CNT_W-1:0] bar_px_q;
    logic [15:0]      bar_colour;

    always_comb begin
        bar_colour = 16'h0000;
        case (bar_q)
            3'd0: bar_colour = 16'hFFFF;
            3'd1: bar_colour = 16'hFFE0;
            3'd2: bar_colour = 16'h07FF;
            3'd3: bar_colour = 16'h07E0;
            3'd4: bar_colour = 16'hF81F;
            3'd5: bar_colour = 16'hF800;
            3'd6: bar_colour = 16'h001F;
            3'd7: bar_colour = 16'h0000;
        endcase
    end

    // The source selection is sampled live in SYNC and frozen for the rest of the frame.
    assign pat_mode  = (state_q == S_SYNC) ? pattern_sel : pat_q;
    assign src_valid = pat_mode | pix_valid;
    assign src_sof   = pat_mode ? (state_q == S_SYNC) : pix_sof;
    assign src_data  = pat_mode ? bar_colour : pix_data;
    assign pix_ready = rdy_int & ~pat_mode;

    always_ff @(posedge clk_lcd) begin
        if (lcd_rst) begin
            pat_q    <= 1'b0;
            bar_q    <= 3'd0;
            bar_px_q <= '0;
        end else begin
            if (state_q == S_SYNC) begin
                pat_q <= pattern_sel;
            end
            if (state_q == S_IDLE || state_q == S_DONE) begin
                bar_q    <= 3'd0;
                bar_px_q <= '0;
            end else if (pat_mode && accept) begin
                if (bar_px_q == CNT_W'(BAR_W - 1)) begin
                    bar_px_q <= '0;
                    bar_q    <= bar_q + 3'd1;
                end else begin
                    bar_px_q <= bar_px_q + CNT_W'(1);
                end
            end
        end
    end
`else
    assign src_valid = pix_valid;
    assign src_sof   = pix_sof;
    assign src_data  = pix_data;
    assign pix_ready = rdy_int;
`endif

    always_ff @(posedge clk_lcd) begin
        if (lcd_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hold_q    <= 16'h0000;
            data_q    <= 16'h0000;
            we_q      <= 1'b0;
            wr_load_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fcnt_q    <= 8'd0;
        end else begin
            we_q      <= 1'b0;
            wr_load_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            if (!sdram_init_done) begin
                // Losing the controller abandons the frame; an already-registered write still drains.
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_SYNC;
                    end
                    S_SYNC: begin
                        if (accept && src_sof) begin
                            hold_q    <= src_data;
                            wr_load_q <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        we_q    <= 1'b1;
                        data_q  <= hold_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (accept) begin
                            if (last_px) begin
                                we_q    <= 1'b1;
                                data_q  <= src_data;
                                cnt_q   <= cnt_q + CNT_W'(1);
                                done_q  <= 1'b1;
                                fcnt_q  <= fcnt_q + 8'd1;
                                state_q <= S_DONE;
                            end else if (src_sof) begin
                                // Short frame: the sof beat becomes pixel 0 of the next frame.
                                err_q     <= 1'b1;
                                hold_q    <= src_data;
                                wr_load_q <= 1'b1;
                                state_q   <= S_LOAD;
                            end else begin
                                we_q   <= 1'b1;
                                data_q <= src_data;
                                cnt_q  <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        cnt_q   <= '0;
                        state_q <= S_SYNC;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sys_we      = we_q;
    assign sys_data_in = data_q;
    assign wr_load     = wr_load_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_cnt   = fcnt_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Bench for sdram_frame_writer with an 8x4 frame: random pixel streams scored against an expected-write queue.
module tb_sdram_frame_writer;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int TOT = H * V;

  logic        clk_lcd = 1'b0;
  logic        lcd_rst;
  logic        sdram_init_done;
  logic        wfifo_afull;
  logic        pix_valid;
  logic        pix_sof;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        wr_load;
  logic        frame_done;
  logic        frame_err;
  logic [7:0]  frame_cnt;
  logic [2:0]  state_dbg;
`ifdef FRAME_WRITER_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          n_writes = 0;
  int          n_load = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          afull_mode = 0;
  int          frames_total = 0;
  bit          framing = 1'b0;

  // clock / reset
  always #5 clk_lcd = ~clk_lcd;

  sdram_frame_writer #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .CNT_W(6)
  ) dut (
    .clk_lcd(clk_lcd),
    .lcd_rst(lcd_rst),
    .sdram_init_done(sdram_init_done),
    .wfifo_afull(wfifo_afull),
`ifdef FRAME_WRITER_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .sys_we(sys_we),
    .sys_data_in(sys_data_in),
    .wr_load(wr_load),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .state_dbg_o(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock of stimulus, then score whatever the DUT produced after the edge
  task automatic step(input logic v, input logic s, input logic [15:0] d, output bit acc);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    case (afull_mode)
      0:       wfifo_afull = 1'b0;
      1:       wfifo_afull = ((cyc / 3) % 2) == 1;
      default: wfifo_afull = ($urandom_range(0, 3) == 0);
    endcase
    #1;
    acc = (v === 1'b1) && (pix_ready === 1'b1);
    if (framing && wfifo_afull) chk("ready_while_afull", 32'(pix_ready), 0);
    @(posedge clk_lcd);
    #1;
    cyc++;
    if (sys_we === 1'b1) begin
      n_writes++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write got=%0h want=none", sys_data_in);
      end
      if (exp_q.size() != 0) chk("wr_data", 32'(sys_data_in), 32'(exp_q.pop_front()));
    end
    if (wr_load === 1'b1) n_load++;
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), acc);
  endtask

  task automatic send_beat(input logic s, input logic [15:0] d, input bit gaps);
    bit acc;
    int w;
    if (gaps) idle($urandom_range(0, 2));
    acc = 1'b0;
    w = 0;
    while (!acc && w < 40) begin
      step(1'b1, s, d, acc);
      w++;
    end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL beat_timeout got=%0d want=<40", w);
    end
  endtask

  // n beats starting with sof; pushes each beat into the expected write queue
  task automatic send_frame(input int n, input bit ramp, input bit gaps, input bit sof_last);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = ramp ? 16'(i) : 16'($urandom_range(0, 65535));
      exp_q.push_back(d);
      send_beat((i == 0) || (sof_last && i == n - 1), d, gaps);
      if (i == 0) framing = 1'b1;
    end
    if (n == TOT) framing = 1'b0;
  endtask

  initial begin
    int w0, l0, d0, e0;
    bit acc;
    lcd_rst = 1'b1;
    sdram_init_done = 1'b0;
    wfifo_afull = 1'b0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_data = 16'h0000;
    idle(3);
    chk("rst_sys_we", 32'(sys_we), 0);
    chk("rst_wr_load", 32'(wr_load), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    lcd_rst = 1'b0;

    // controller not ready: stream is refused entirely
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), acc);
      chk("noinit_ready", 32'(pix_ready), 0);
      chk("noinit_we", 32'(sys_we), 0);
      chk("noinit_load", 32'(wr_load), 0);
    end

    // ramp frame after 3 discarded pixels
    sdram_init_done = 1'b1;
    w0 = n_writes; l0 = n_load; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 3; i++) send_beat(1'b0, 16'($urandom_range(0, 65535)), 1'b0);
    send_frame(TOT, 1'b1, 1'b0, 1'b0);
    frames_total++;
    idle(4);
    chk("ramp_writes", 32'(n_writes - w0), TOT);
    chk("ramp_loads", 32'(n_load - l0), 1);
    chk("ramp_done", 32'(n_done - d0), 1);
    chk("ramp_err", 32'(n_err - e0), 0);
    chk("ramp_q_empty", 32'(exp_q.size()), 0);
    chk("ramp_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

    // almost-full toggling every 3 cycles, random gaps and stray sof without valid
    afull_mode = 1;
    w0 = n_writes; d0 = n_done;
    send_frame(TOT, 1'b0, 1'b1, 1'b0);
    frames_total++;
    idle(4);
    afull_mode = 0;
    chk("afull_writes", 32'(n_writes - w0), TOT);
    chk("afull_done", 32'(n_done - d0), 1);
    chk("afull_q_empty", 32'(exp_q.size()), 0);
    chk("afull_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

    // short frame: sof arrives as pixel 20, then a full frame follows
    w0 = n_writes; l0 = n_load; d0 = n_done; e0 = n_err;
    send_frame(20, 1'b0, 1'b0, 1'b0);
    send_frame(TOT, 1'b0, 1'b0, 1'b0);
    frames_total++;
    idle(4);
    chk("short_writes", 32'(n_writes - w0), 20 + TOT);
    chk("short_loads", 32'(n_load - l0), 2);
    chk("short_err", 32'(n_err - e0), 1);
    chk("short_done", 32'(n_done - d0), 1);
    chk("short_q_empty", 32'(exp_q.size()), 0);
    chk("short_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

    // sof on the very last pixel is an ordinary last pixel
    d0 = n_done; e0 = n_err;
    send_frame(TOT, 1'b0, 1'b0, 1'b1);
    frames_total++;
    idle(4);
    chk("lastsof_err", 32'(n_err - e0), 0);
    chk("lastsof_done", 32'(n_done - d0), 1);
    chk("lastsof_q_empty", 32'(exp_q.size()), 0);

    // back-to-back frames until the completed-frame counter wraps to 0
    afull_mode = 2;
    d0 = n_done;
    for (int f = 0; f < 252; f++) begin
      send_frame(TOT, 1'b0, 1'b0, 1'b0);
      frames_total++;
    end
    afull_mode = 0;
    idle(4);
    chk("wrap_done", 32'(n_done - d0), 252);
    chk("wrap_q_empty", 32'(exp_q.size()), 0);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

    // controller drops mid-frame: writes stop, then a clean frame resyncs
    send_frame(11, 1'b0, 1'b0, 1'b0);
    sdram_init_done = 1'b0;
    framing = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 16'($urandom_range(0, 65535)), acc);
      chk("drop_we", 32'(sys_we), 0);
      chk("drop_ready", 32'(pix_ready), 0);
    end
    chk("drop_q_empty", 32'(exp_q.size()), 0);
    sdram_init_done = 1'b1;
    send_frame(TOT, 1'b0, 1'b0, 1'b0);
    frames_total++;
    idle(4);
    chk("resync_q_empty", 32'(exp_q.size()), 0);
    chk("resync_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

    // reset mid-frame returns everything to reset values
    send_frame(5, 1'b0, 1'b0, 1'b0);
    lcd_rst = 1'b1;
    framing = 1'b0;
    idle(1);
    frames_total = 0;
    chk("mrst_we", 32'(sys_we), 0);
    chk("mrst_frame_cnt", 32'(frame_cnt), 0);
    chk("mrst_ready", 32'(pix_ready), 0);
    chk("mrst_q_empty", 32'(exp_q.size()), 0);
    lcd_rst = 1'b0;
    send_frame(TOT, 1'b0, 1'b1, 1'b0);
    frames_total++;
    idle(4);
    chk("post_rst_q_empty", 32'(exp_q.size()), 0);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'(frames_total % 256));

`ifdef FRAME_WRITER_PATTERN_EN
    begin
      logic [15:0] bars [8];
      int wt;
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      for (int i = 0; i < TOT; i++) exp_q.push_back(bars[((i % H) / (H / 8)) % 8]);
      d0 = n_done; l0 = n_load; w0 = n_writes;
      pattern_sel = 1'b1;
      wt = 0;
      while (n_done == d0 && wt < 200) begin
        step(1'b0, 1'b0, 16'h0000, acc);
        chk("pat_ready", 32'(pix_ready), 0);
        if (n_load != l0) pattern_sel = 1'b0;
        wt++;
      end
      idle(4);
      chk("pat_writes", 32'(n_writes - w0), TOT);
      chk("pat_done", 32'(n_done - d0), 1);
      chk("pat_q_empty", 32'(exp_q.size()), 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
